// File: rtl/lcd_config_seq.sv
// lcd_config_seq: once the init block releases the bus, sends the display
// configuration commands and then writes stored messages from character memory.
// Ports: clk; reset (async, active-high); start (init block owns the bus);
//   char_data (byte at mem_addr); cmd_done (transfer-finished pulse);
//   cmd_data/cmd_rs/cmd_rw/cmd_valid (request to the nibble-transfer FSM);
//   mem_addr (character memory address); msg_done (message written pulse);
//   err (sticky flag, set when a command times out).
`timescale 1ns/1ps
module lcd_config_seq #(
   parameter int CHARS_PER_LINE = 16,
   parameter int NUM_LINES      = 2,
   parameter int NUM_MSGS       = 2,
   parameter int MEM_AW         = 11,
   parameter int CLR_WAIT       = 82000,
   parameter int HOLD_CYCLES    = 50000000,
   parameter int CMD_TIMEOUT    = 4095,
   parameter int AUTO_INC       = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        char_data,
   input  logic              cmd_done,
   output logic [7:0]        cmd_data,
   output logic              cmd_rs,
   output logic              cmd_rw,
   output logic              cmd_valid,
   output logic [MEM_AW-1:0] mem_addr,
   output logic              msg_done,
   output logic              err
);

   localparam int MSG_SIZE = CHARS_PER_LINE * NUM_LINES;
   localparam int MI_W     = (NUM_MSGS > 1) ? $clog2(NUM_MSGS) : 1;
   localparam int MAX_AB   = (CLR_WAIT > HOLD_CYCLES) ? CLR_WAIT : HOLD_CYCLES;
   localparam int CNT_MAX  = (MAX_AB > CMD_TIMEOUT) ? MAX_AB : CMD_TIMEOUT;
   localparam int CNT_W    = $clog2(CNT_MAX + 1);

   typedef enum logic [2:0] {
      FSET, EMODE, DISPON, CLEAR, CLRWAIT, SETADDR, WRCHAR, HOLD
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             line;
   logic [5:0]       col;
   logic [MI_W-1:0]  msg_idx;
   logic             last_col;
   logic             last_line;
   logic             tmo;
   logic [7:0]       cmd_byte;

   assign last_col  = (col == 6'(CHARS_PER_LINE - 1));
   assign last_line = (line == 1'(NUM_LINES - 1));
   assign tmo       = (cnt == CNT_W'(CMD_TIMEOUT - 1));

   // col never exceeds 39, so {1,line,col} equals 0x80 | (line*0x40 + col)
   always_comb begin
      cmd_byte = 8'h00;
      case (state)
         FSET:    cmd_byte = 8'h28;
         EMODE:   cmd_byte = 8'h06;
         DISPON:  cmd_byte = 8'h0C;
         CLEAR:   cmd_byte = 8'h01;
         SETADDR: cmd_byte = {1'b1, line, col};
         WRCHAR:  cmd_byte = char_data;
         default: cmd_byte = 8'h00;
      endcase
   end

   always_comb begin
      mem_addr = MEM_AW'(msg_idx) * MEM_AW'(MSG_SIZE)
               + MEM_AW'(line) * MEM_AW'(CHARS_PER_LINE)
               + MEM_AW'(col);
   end

   // A command state spends one cycle with cmd_valid low (loading the byte,
   // which also lets mem_addr settle for WRCHAR), then requests until done
   // or timeout.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= FSET;
         cnt       <= '0;
         line      <= 1'b0;
         col       <= '0;
         msg_idx   <= '0;
         cmd_valid <= 1'b0;
         cmd_rs    <= 1'b0;
         cmd_rw    <= 1'b1;
         cmd_data  <= 8'h00;
         msg_done  <= 1'b0;
         err       <= 1'b0;
      end else begin
         msg_done <= 1'b0;
         if (start) begin
            state     <= FSET;
            cnt       <= '0;
            line      <= 1'b0;
            col       <= '0;
            cmd_valid <= 1'b0;
            cmd_rs    <= 1'b0;
            cmd_rw    <= 1'b1;
            cmd_data  <= 8'h00;
         end else begin
            case (state)
               FSET, EMODE, DISPON, CLEAR, SETADDR, WRCHAR: begin
                  if (!cmd_valid) begin
                     cmd_valid <= 1'b1;
                     cmd_rw    <= 1'b0;
                     cmd_rs    <= (state == WRCHAR);
                     cmd_data  <= cmd_byte;
                     cnt       <= '0;
                  end else if (cmd_done || tmo) begin
                     // done on the timeout edge still counts as done
                     if (!cmd_done) err <= 1'b1;
                     cmd_valid <= 1'b0;
                     cmd_rw    <= 1'b1;
                     cnt       <= '0;
                     case (state)
                        FSET:    state <= EMODE;
                        EMODE:   state <= DISPON;
                        DISPON:  state <= CLEAR;
                        CLEAR:   state <= CLRWAIT;
                        SETADDR: state <= WRCHAR;
                        WRCHAR: begin
                           if (!last_col) begin
                              col   <= col + 1'b1;
                              state <= (AUTO_INC != 0) ? WRCHAR : SETADDR;
                           end else if (!last_line) begin
                              col   <= '0;
                              line  <= line + 1'b1;
                              state <= SETADDR;
                           end else begin
                              msg_done <= 1'b1;
                              state    <= HOLD;
                           end
                        end
                        default: state <= FSET;
                     endcase
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               CLRWAIT: begin
                  // the wait itself is the request gap: issue 0x80 directly
                  if (cnt == CNT_W'(CLR_WAIT - 1)) begin
                     state     <= SETADDR;
                     line      <= 1'b0;
                     col       <= '0;
                     cnt       <= '0;
                     cmd_valid <= 1'b1;
                     cmd_rw    <= 1'b0;
                     cmd_rs    <= 1'b0;
                     cmd_data  <= 8'h80;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               HOLD: begin
                  if (cnt == CNT_W'(HOLD_CYCLES - 1)) begin
                     state <= FSET;
                     cnt   <= '0;
                     line  <= 1'b0;
                     col   <= '0;
                     if (msg_idx == MI_W'(NUM_MSGS - 1)) msg_idx <= '0;
                     else msg_idx <= msg_idx + 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
               default: state <= FSET;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lcd_config_seq.sv
// tb_lcd_config_seq: drives two lcd_config_seq instances (AUTO_INC 0 and 1)
// with a random-latency transfer responder and checks against a message model.
`timescale 1ns/1ps
module tb_lcd_config_seq;

   localparam int CPL   = 16;
   localparam int NL    = 2;
   localparam int NM    = 2;
   localparam int AW    = 11;
   localparam int CLRW  = 200;
   localparam int HOLDC = 300;
   localparam int TMO   = 40;

   typedef struct packed {
      logic [15:0] gap;
      logic [15:0] hi;
      logic [15:0] req;
      logic        rs;
      logic [7:0]  data;
      logic [10:0] addr;
   } ent_t;

   typedef struct {
      int data;
      int rs;
      int addr;
      int gap;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start;
   logic [7:0]    chd [2];
   logic          cdn [2];
   logic [7:0]    cd  [2];
   logic          crs [2];
   logic          crw [2];
   logic          cv  [2];
   logic          mdn [2];
   logic          er  [2];
   logic [AW-1:0] ma  [2];
   logic [7:0]    mem [0:2047];

   ent_t          q0 [$];
   ent_t          q1 [$];
   exp_t          eq [$];
   logic [AW-1:0] mda [$];
   ent_t          cur [2];
   int            lowc [2];
   int            hic [2];
   int            tgt [2];
   int            md_rise [2];
   int            md_high [2];
   logic          md_prev [2];
   bit            resp_en [2];
   bit            spur_en [2];
   int            fix_dly [2];
   int            stab_err;
   int            errors;
   int            checks;

   always #5 clk = ~clk;

   assign chd[0] = mem[ma[0]];
   assign chd[1] = mem[ma[1]];

   lcd_config_seq #(
      .CHARS_PER_LINE(CPL), .NUM_LINES(NL), .NUM_MSGS(NM), .MEM_AW(AW),
      .CLR_WAIT(CLRW), .HOLD_CYCLES(HOLDC), .CMD_TIMEOUT(TMO), .AUTO_INC(0)
   ) dut0 (
      .clk(clk), .reset(reset), .start(start), .char_data(chd[0]),
      .cmd_done(cdn[0]), .cmd_data(cd[0]), .cmd_rs(crs[0]), .cmd_rw(crw[0]),
      .cmd_valid(cv[0]), .mem_addr(ma[0]), .msg_done(mdn[0]), .err(er[0])
   );

   lcd_config_seq #(
      .CHARS_PER_LINE(CPL), .NUM_LINES(NL), .NUM_MSGS(NM), .MEM_AW(AW),
      .CLR_WAIT(CLRW), .HOLD_CYCLES(HOLDC), .CMD_TIMEOUT(TMO), .AUTO_INC(1)
   ) dut1 (
      .clk(clk), .reset(reset), .start(start), .char_data(chd[1]),
      .cmd_done(cdn[1]), .cmd_data(cd[1]), .cmd_rs(crs[1]), .cmd_rw(crw[1]),
      .cmd_valid(cv[1]), .mem_addr(ma[1]), .msg_done(mdn[1]), .err(er[1])
   );

   // Transfer responder and command logger, both on the falling edge.
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            cdn[i]     = 1'b0;
            lowc[i]    = 0;
            hic[i]     = 0;
            md_prev[i] = 1'b0;
         end else begin
            if (mdn[i]) begin
               md_high[i]++;
               if (!md_prev[i]) begin
                  md_rise[i]++;
                  if (i == 0) mda.push_back(ma[0]);
               end
            end
            md_prev[i] = mdn[i];
            if (cv[i]) begin
               if (hic[i] == 0) begin
                  cur[i].gap  = 16'(lowc[i]);
                  cur[i].rs   = crs[i];
                  cur[i].data = cd[i];
                  cur[i].addr = ma[i];
                  if (!resp_en[i]) tgt[i] = 0;
                  else if (fix_dly[i] != 0) tgt[i] = fix_dly[i];
                  else tgt[i] = int'($urandom_range(1, 4));
                  cur[i].req = 16'(tgt[i]);
                  lowc[i] = 0;
               end else if (cd[i] !== cur[i].data || crs[i] !== cur[i].rs ||
                            crw[i] !== 1'b0 || ma[i] !== cur[i].addr) begin
                  stab_err++;
               end
               hic[i]++;
               cdn[i] = (tgt[i] != 0 && hic[i] == tgt[i]);
            end else begin
               if (hic[i] != 0) begin
                  cur[i].hi = 16'(hic[i]);
                  if (i == 0) q0.push_back(cur[i]);
                  else q1.push_back(cur[i]);
                  hic[i] = 0;
               end
               lowc[i]++;
               cdn[i] = spur_en[i] && ($urandom_range(0, 3) == 0);
            end
         end
      end
   end

   function automatic int qsize(input int i);
      return (i == 0) ? q0.size() : q1.size();
   endfunction

   task automatic wait_q(input int i, input int n, input int budget,
                         output bit ok);
      ok = 1'b0;
      for (int k = 0; k < budget; k++) begin
         @(posedge clk);
         #1;
         if (qsize(i) >= n) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   // Expected command stream of one message, straight from the display rules.
   task automatic build_exp(input int idx, input bit ai, input int g0);
      exp_t e;
      eq.delete();
      e = '{data: 'h28, rs: 0, addr: -1, gap: g0}; eq.push_back(e);
      e = '{data: 'h06, rs: 0, addr: -1, gap: 1};  eq.push_back(e);
      e = '{data: 'h0C, rs: 0, addr: -1, gap: 1};  eq.push_back(e);
      e = '{data: 'h01, rs: 0, addr: -1, gap: 1};  eq.push_back(e);
      for (int l = 0; l < NL; l++) begin
         for (int c = 0; c < CPL; c++) begin
            int a;
            a = idx * CPL * NL + l * CPL + c;
            if (!ai || c == 0) begin
               e.data = 'h80 + l * 'h40 + c;
               e.rs   = 0;
               e.addr = -1;
               e.gap  = (l == 0 && c == 0) ? CLRW : 1;
               eq.push_back(e);
            end
            e.data = int'(mem[a]);
            e.rs   = 1;
            e.addr = a;
            e.gap  = 1;
            eq.push_back(e);
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b0;
      start = 1'b0;
      #2 reset = 1'b1;
      repeat (3) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (cv[d] !== 1'b0 || crw[d] !== 1'b1 || crs[d] !== 1'b0 ||
             cd[d] !== 8'h00 || mdn[d] !== 1'b0 || er[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs dut%0d: v=%b rw=%b rs=%b d=%h md=%b err=%b",
                     d, cv[d], crw[d], crs[d], cd[d], mdn[d], er[d]);
         end
         checks++;
         if (ma[d] !== '0) begin
            errors++;
            $display("FAIL reset_addr dut%0d: got %0d want 0", d, ma[d]);
         end
      end
   endtask

   task automatic test_first_sequence;
      bit ok;
      int want [5];
      want = '{'h28, 'h06, 'h0C, 'h01, 'h80};
      fix_dly = '{3, 3};
      @(negedge clk);
      reset = 1'b0;
      wait_q(0, 5, 2000, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL first_seq_wait: got %0d cmds want 5", q0.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            checks++;
            if (q0[k].data !== 8'(want[k]) || q0[k].hi !== 16'd3 ||
                q0[k].rs !== 1'b0) begin
               errors++;
               $display("FAIL first_seq[%0d]: got %h hi=%0d want %h hi=3",
                        k, q0[k].data, q0[k].hi, want[k]);
            end
         end
         checks++;
         if (q0[1].gap !== 16'd1 || q0[4].gap !== 16'(CLRW)) begin
            errors++;
            $display("FAIL first_seq_gaps: got %0d/%0d want 1/%0d",
                     q0[1].gap, q0[4].gap, CLRW);
         end
      end
      fix_dly = '{0, 0};
      spur_en = '{1'b1, 1'b1};
   endtask

   task automatic test_messages;
      for (int k = 0; k < 3; k++) begin
         bit ok;
         ok = 1'b0;
         for (int c = 0; c < 4000; c++) begin
            @(posedge clk);
            #1;
            if (md_rise[0] >= k + 1 && md_rise[1] >= k + 1) begin
               ok = 1'b1;
               break;
            end
         end
         checks++;
         if (!ok) begin
            errors++;
            $display("FAIL msg%0d_wait: msg_done counts %0d/%0d",
                     k, md_rise[0], md_rise[1]);
            return;
         end
         for (int d = 0; d < 2; d++) begin
            build_exp(k % NM, d == 1, (k == 0) ? -1 : HOLDC + 1);
            checks++;
            if (qsize(d) < eq.size()) begin
               errors++;
               $display("FAIL msg%0d_count dut%0d: got %0d want %0d",
                        k, d, qsize(d), eq.size());
               return;
            end
            for (int n = 0; eq.size() > 0; n++) begin
               exp_t e;
               ent_t g;
               e = eq.pop_front();
               if (d == 0) g = q0.pop_front();
               else g = q1.pop_front();
               checks++;
               if (g.data !== 8'(e.data) || g.rs !== 1'(e.rs) ||
                   (e.addr >= 0 && g.addr !== AW'(e.addr)) ||
                   (e.gap >= 0 && g.gap !== 16'(e.gap)) || g.hi !== g.req) begin
                  errors++;
                  $display("FAIL msg%0d dut%0d cmd%0d: got d=%h rs=%b a=%0d gap=%0d hi=%0d want d=%h rs=%0d a=%0d gap=%0d hi=%0d",
                           k, d, n, g.data, g.rs, g.addr, g.gap, g.hi,
                           e.data, e.rs, e.addr, e.gap, g.req);
               end
            end
         end
      end
      checks++;
      if (md_rise[0] !== 3 || md_high[0] !== md_rise[0]) begin
         errors++;
         $display("FAIL msg_done_pulse: got %0d pulses %0d high cycles want 3/3",
                  md_rise[0], md_high[0]);
      end
      checks++;
      if (mda.size() != 3 || mda[0] !== 11'd31 || mda[1] !== 11'd63 ||
          mda[2] !== 11'd31) begin
         errors++;
         $display("FAIL msg_done_addr: got n=%0d %0d %0d %0d want 31 63 31",
                  mda.size(), mda[0], mda[1], mda[2]);
      end
      checks++;
      if (er[0] !== 1'b0 || er[1] !== 1'b0) begin
         errors++;
         $display("FAIL err_normal: got %b%b want 00", er[0], er[1]);
      end
   endtask

   task automatic test_start_abort;
      bit ok;
      ok = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk);
         #2;
         if (cv[0] && crs[0]) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL start_find_wrchar: no data write seen");
         return;
      end
      start = 1'b1;
      @(posedge clk);
      #2;
      checks++;
      if (cv[0] !== 1'b0 || crw[0] !== 1'b1 || cd[0] !== 8'h00) begin
         errors++;
         $display("FAIL start_idle: got v=%b rw=%b d=%h want 0 1 00",
                  cv[0], crw[0], cd[0]);
      end
      checks++;
      if (ma[0] !== 11'd32) begin
         errors++;
         $display("FAIL start_addr: got %0d want 32", ma[0]);
      end
      repeat (4) @(posedge clk);
      #2;
      q0.delete();
      q1.delete();
      start = 1'b0;
      @(posedge clk);
      #2;
      checks++;
      if (cv[0] !== 1'b1 || cd[0] !== 8'h28) begin
         errors++;
         $display("FAIL start_restart: got v=%b d=%h want 1 28", cv[0], cd[0]);
      end
      wait_q(0, 6, 2000, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL start_seq_wait: got %0d cmds want 6", q0.size());
      end else begin
         checks++;
         if (q0[0].data !== 8'h28 || q0[1].data !== 8'h06 ||
             q0[2].data !== 8'h0C || q0[3].data !== 8'h01 ||
             q0[4].data !== 8'h80) begin
            errors++;
            $display("FAIL start_seq: got %h %h %h %h %h want 28 06 0c 01 80",
                     q0[0].data, q0[1].data, q0[2].data, q0[3].data,
                     q0[4].data);
         end
         checks++;
         if (q0[5].rs !== 1'b1 || q0[5].addr !== 11'd32 ||
             q0[5].data !== mem[32]) begin
            errors++;
            $display("FAIL start_msg_kept: got rs=%b a=%0d d=%h want 1 32 %h",
                     q0[5].rs, q0[5].addr, q0[5].data, mem[32]);
         end
      end
   endtask

   task automatic test_timeout;
      bit ok;
      @(posedge clk);
      #2;
      reset = 1'b1;
      resp_en[0] = 1'b1;
      fix_dly[0] = TMO;
      @(posedge clk);
      #2;
      q0.delete();
      q1.delete();
      reset = 1'b0;
      wait_q(0, 1, 500, ok);
      checks++;
      if (!ok || q0[0].data !== 8'h28 || q0[0].hi !== 16'(TMO) ||
          er[0] !== 1'b0) begin
         errors++;
         $display("FAIL done_at_timeout: got d=%h hi=%0d err=%b want 28 %0d 0",
                  q0[0].data, q0[0].hi, er[0], TMO);
      end
      resp_en[0] = 1'b0;
      wait_q(0, 5, 1500, ok);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL timeout_wait: got %0d cmds want 5", q0.size());
         return;
      end
      for (int k = 1; k < 5; k++) begin
         checks++;
         if (q0[k].hi !== 16'(TMO) || q0[k].req !== 16'd0) begin
            errors++;
            $display("FAIL timeout_len[%0d]: got hi=%0d want %0d",
                     k, q0[k].hi, TMO);
         end
      end
      checks++;
      if (q0[1].data !== 8'h06 || q0[3].data !== 8'h01 ||
          q0[4].data !== 8'h80) begin
         errors++;
         $display("FAIL timeout_advance: got %h %h %h want 06 01 80",
                  q0[1].data, q0[3].data, q0[4].data);
      end
      checks++;
      if (er[0] !== 1'b1) begin
         errors++;
         $display("FAIL timeout_err: got %b want 1", er[0]);
      end
      resp_en[0] = 1'b1;
      fix_dly[0] = 0;
      wait_q(0, 6, 500, ok);
      checks++;
      if (!ok || er[0] !== 1'b1 || q0[5].hi !== q0[5].req) begin
         errors++;
         $display("FAIL err_sticky: got err=%b hi=%0d want 1 hi=%0d",
                  er[0], q0[5].hi, q0[5].req);
      end
      ok = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(posedge clk);
         #2;
         if (cv[0]) begin
            ok = 1'b1;
            break;
         end
      end
      #1 reset = 1'b1;
      #1;
      checks++;
      if (!ok || cv[0] !== 1'b0 || crw[0] !== 1'b1 || er[0] !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: got v=%b rw=%b err=%b want 0 1 0",
                  cv[0], crw[0], er[0]);
      end
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
   endtask

   task automatic test_stability;
      checks++;
      if (stab_err !== 0) begin
         errors++;
         $display("FAIL request_stability: got %0d changes want 0", stab_err);
      end
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      stab_err = 0;
      md_rise  = '{0, 0};
      md_high  = '{0, 0};
      resp_en  = '{1'b1, 1'b1};
      spur_en  = '{1'b0, 1'b0};
      fix_dly  = '{0, 0};
      for (int i = 0; i < 2048; i++) mem[i] = 8'($urandom);
      test_reset;
      test_first_sequence;
      test_messages;
      test_start_abort;
      test_timeout;
      test_stability;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
